// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StXfer,
      StDone
   } spiStateE;

   localparam int unsigned BitsPerXfer  = 8;
   localparam int unsigned EdgesPerXfer = 16;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: emits a one-cycle tick every CLK_DIV_COUNT enabled cycles.
module spi_clk_div #(
   parameter int unsigned CLK_DIV_COUNT = 10
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEnable,
   output logic oTick
);

   localparam int unsigned DivW = (CLK_DIV_COUNT > 1) ? $clog2(CLK_DIV_COUNT) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV_COUNT - 1);

   logic [DivW-1:0] divQ;

   // Held at zero while disabled so every transfer starts from a fresh count.
   always_ff @(posedge iClk) begin
      if (iRst || !iEnable) begin
         divQ <= '0;
      end else if (divQ == DivLast) begin
         divQ <= '0;
      end else begin
         divQ <= divQ + DivW'(1);
      end
   end

   assign oTick = iEnable && (divQ == DivLast);

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, all four CPOL/CPHA modes, MSB first.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV_COUNT = 10
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iCpol,
   input  logic                   iCpha,
   input  logic [BitsPerXfer-1:0] iDin,
   input  logic                   iStart,
   output logic [BitsPerXfer-1:0] oDout,
   output logic                   oReady,
   output logic                   oSpiCs,
   output logic                   oSpiClk,
   output logic                   oSpiMosi,
   input  logic                   iSpiMiso
);

   localparam int unsigned EdgeW = $clog2(EdgesPerXfer + 1);
   localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(EdgesPerXfer - 1);

   spiStateE stateQ, stateD;
   logic [BitsPerXfer-1:0] txQ, txD, rxQ, rxD, doutQ, doutD;
   logic [EdgeW-1:0] edgeQ, edgeD;
   logic cpolQ, cpolD, cphaQ, cphaD;
   logic readyQ, readyD, csQ, csD, sclkQ, sclkD, mosiQ, mosiD;
   logic divEn, tick, leading;

   assign divEn = (stateQ != StIdle);
   // Even count of completed toggles means the coming toggle is a leading edge.
   assign leading = ~edgeQ[0];

   spi_clk_div #(
      .CLK_DIV_COUNT(CLK_DIV_COUNT)
   ) uClkDiv (
      .iClk   (iClk),
      .iRst   (iRst),
      .iEnable(divEn),
      .oTick  (tick)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stateQ <= StIdle;
         txQ    <= '0;
         rxQ    <= '0;
         doutQ  <= '0;
         edgeQ  <= '0;
         cpolQ  <= 1'b0;
         cphaQ  <= 1'b0;
         readyQ <= 1'b1;
         csQ    <= 1'b1;
         sclkQ  <= iCpol;
         mosiQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         txQ    <= txD;
         rxQ    <= rxD;
         doutQ  <= doutD;
         edgeQ  <= edgeD;
         cpolQ  <= cpolD;
         cphaQ  <= cphaD;
         readyQ <= readyD;
         csQ    <= csD;
         sclkQ  <= sclkD;
         mosiQ  <= mosiD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (iStart) stateD = StXfer;
         StXfer:  if (tick && (edgeQ == EdgeLast)) stateD = StDone;
         StDone:  if (tick) stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      txD    = txQ;
      rxD    = rxQ;
      doutD  = doutQ;
      edgeD  = edgeQ;
      cpolD  = cpolQ;
      cphaD  = cphaQ;
      readyD = readyQ;
      csD    = csQ;
      sclkD  = sclkQ;
      mosiD  = mosiQ;
      unique case (stateQ)
         StIdle: begin
            sclkD = iCpol;
            if (iStart) begin
               txD    = iDin;
               cpolD  = iCpol;
               cphaD  = iCpha;
               edgeD  = '0;
               readyD = 1'b0;
               csD    = 1'b0;
               mosiD  = iDin[BitsPerXfer-1];
            end
         end
         StXfer: begin
            if (tick) begin
               sclkD = ~sclkQ;
               edgeD = edgeQ + EdgeW'(1);
               if (leading != cphaQ) begin
                  rxD = {rxQ[BitsPerXfer-2:0], iSpiMiso};
               end
               // CPHA=0 already presented bit 7 at start, so trailing edges move on to bit 6.
               if (cphaQ && leading) begin
                  mosiD = txQ[BitsPerXfer-1];
                  txD   = txQ << 1;
               end else if (!cphaQ && !leading && (edgeQ != EdgeLast)) begin
                  mosiD = txQ[BitsPerXfer-2];
                  txD   = txQ << 1;
               end
            end
         end
         StDone: begin
            sclkD = cpolQ;
            if (tick) begin
               doutD  = rxQ;
               csD    = 1'b1;
               readyD = 1'b1;
               mosiD  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign oDout    = doutQ;
   assign oReady   = readyQ;
   assign oSpiCs   = csQ;
   assign oSpiClk  = sclkQ;
   assign oSpiMosi = mosiQ;

endmodule

// File: tb/tb_spi_master.sv
// Randomised, model-checked bench for spi_master at divider 10 and divider 2.
module tb_spi_master;

   localparam int DivA = 10;
   localparam int DivB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, cpol, cpha;
   logic [7:0] din, slaveByte;
   logic [1:0] readyW, csW, sclkW, mosiW, misoW;
   logic [1:0][7:0] doutW;
   logic [7:0] slaveRx [2];

   spi_master #(.CLK_DIV_COUNT(DivA)) uDutA (
      .iClk(clk), .iRst(rst), .iCpol(cpol), .iCpha(cpha), .iDin(din), .iStart(start),
      .oDout(doutW[0]), .oReady(readyW[0]), .oSpiCs(csW[0]), .oSpiClk(sclkW[0]),
      .oSpiMosi(mosiW[0]), .iSpiMiso(misoW[0])
   );

   spi_master #(.CLK_DIV_COUNT(DivB)) uDutB (
      .iClk(clk), .iRst(rst), .iCpol(cpol), .iCpha(cpha), .iDin(din), .iStart(start),
      .oDout(doutW[1]), .oReady(readyW[1]), .oSpiCs(csW[1]), .oSpiClk(sclkW[1]),
      .oSpiMosi(mosiW[1]), .iSpiMiso(misoW[1])
   );

   // Inputs as seen by the DUTs at each rising edge.
   logic       rstS, startS, cpolS, cphaS;
   logic [7:0] dinS, slaveByteS;
   int         cyc = 0;
   always @(posedge clk) begin
      rstS       <= rst;
      startS     <= start;
      cpolS      <= cpol;
      cphaS      <= cpha;
      dinS       <= din;
      slaveByteS <= slaveByte;
      cyc        <= cyc + 1;
   end

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int divOf(input int i);
      return (i == 0) ? DivA : DivB;
   endfunction

   // Data bit on the wire after n SCLK toggles of a transfer (same rule for MOSI and MISO).
   function automatic int bitIdx(input int n, input bit pha);
      int k;
      if (!pha) k = n / 2;
      else      k = (n == 0) ? 0 : (n - 1) / 2;
      if (k > 7) k = 7;
      return 7 - k;
   endfunction

   // Behavioural model and per-cycle compare.
   initial begin
      bit armed;
      bit busy [2];
      bit justDone [2];
      int t [2];
      logic [7:0] mTx [2], mSlave [2], mDout [2];
      bit mCpol [2], mCpha [2];
      armed = 0;
      forever begin
         @(negedge clk);
         if (rstS === 1'b1) armed = 1;
         if (armed) begin
            for (int i = 0; i < 2; i++) begin
               int d, n;
               logic eReady, eCs, eSclk, eMosi;
               d = divOf(i);
               justDone[i] = 0;
               if (rstS) begin
                  busy[i]  = 0;
                  mDout[i] = 8'h00;
               end else if (!busy[i]) begin
                  if (startS) begin
                     busy[i]   = 1;
                     t[i]      = 0;
                     mTx[i]    = dinS;
                     mCpol[i]  = cpolS;
                     mCpha[i]  = cphaS;
                     mSlave[i] = slaveByteS;
                  end
               end else begin
                  t[i]++;
                  if (t[i] == 17 * d) begin
                     busy[i]     = 0;
                     justDone[i] = 1;
                     mDout[i]    = mSlave[i];
                  end
               end
               if (busy[i]) begin
                  n = t[i] / d;
                  if (n > 16) n = 16;
                  eReady = 1'b0;
                  eCs    = 1'b0;
                  eSclk  = mCpol[i] ^ n[0];
                  eMosi  = mTx[i][bitIdx(n, mCpha[i])];
               end else begin
                  eReady = 1'b1;
                  eCs    = 1'b1;
                  eMosi  = 1'b0;
                  eSclk  = justDone[i] ? mCpol[i] : cpolS;
               end
               check($sformatf("dut%0d ready", i), readyW[i], eReady);
               check($sformatf("dut%0d cs", i), csW[i], eCs);
               check($sformatf("dut%0d sclk", i), sclkW[i], eSclk);
               check($sformatf("dut%0d mosi", i), mosiW[i], eMosi);
               check($sformatf("dut%0d dout", i), doutW[i], mDout[i]);
            end
         end
      end
   end

   // SPI slave: shifts its byte out MSB first and records MOSI on its sample edges.
   initial begin
      bit act [2];
      bit sCph [2];
      int sn [2];
      logic prev [2];
      logic [7:0] sb [2];
      misoW = 2'b00;
      act[0] = 0;
      act[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (csW[i] !== 1'b0) begin
               act[i]   = 0;
               misoW[i] = slaveByteS[7];
            end else begin
               if (!act[i]) begin
                  act[i]     = 1;
                  sb[i]      = slaveByteS;
                  sCph[i]    = cphaS;
                  sn[i]      = 0;
                  prev[i]    = sclkW[i];
                  slaveRx[i] = 8'h00;
               end else if (sclkW[i] !== prev[i]) begin
                  prev[i] = sclkW[i];
                  sn[i]++;
                  if (sn[i][0] ^ sCph[i]) slaveRx[i] = {slaveRx[i][6:0], mosiW[i]};
               end
               misoW[i] = sb[i][bitIdx(sn[i], sCph[i])];
            end
         end
      end
   end

   task automatic waitIdle();
      int k;
      k = 0;
      while ((readyW !== 2'b11) && (k < 500)) begin
         @(negedge clk);
         k++;
      end
      check("idle wait", readyW, 2'b11);
   endtask

   task automatic launch(input bit pol, input bit pha, input logic [7:0] d,
                         input logic [7:0] s, input int hold, output int t0);
      waitIdle();
      cpol      = pol;
      cpha      = pha;
      din       = d;
      slaveByte = s;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      repeat (hold - 1) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone0(input int t0, input bit scramble, output int dt);
      int k;
      k = 0;
      while ((readyW[0] !== 1'b1) && (k < 400)) begin
         @(negedge clk);
         if (scramble) begin
            din  = 8'($urandom);
            cpha = 1'($urandom);
         end
         k++;
      end
      dt = cyc - t0;
      check("done wait", readyW[0], 1'b1);
   endtask

   initial begin
      int t0, dt, r1, r2, dB;
      logic p;
      rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; din = 8'h00; slaveByte = 8'h00;
      repeat (3) @(negedge clk);
      check("reset ready", readyW, 2'b11);
      check("reset cs", csW, 2'b11);
      check("reset mosi", mosiW, 2'b00);
      check("reset sclk", sclkW, 2'b00);
      check("reset dout", doutW[0], 8'h00);
      rst = 1'b0;

      // Mode 3 with a two-cycle start pulse.
      launch(1'b1, 1'b1, 8'h5A, 8'h3C, 2, t0);
      waitDone0(t0, 1'b0, dt);
      check("m3 busy cycles", dt, 170);
      check("m3 dout", doutW[0], 8'h3C);
      check("m3 mosi bits", slaveRx[0], 8'h5A);
      @(negedge clk);
      check("m3 no restart", readyW[0], 1'b1);

      // Mode 0: MOSI valid before the first rising edge.
      launch(1'b0, 1'b0, 8'hA5, 8'hC3, 1, t0);
      check("m0 early mosi", mosiW[0], 1'b1);
      check("m0 early sclk", sclkW[0], 1'b0);
      waitDone0(t0, 1'b0, dt);
      check("m0 dout", doutW[0], 8'hC3);
      check("m0 idle sclk", sclkW[0], 1'b0);

      // Modes 1 and 2 against a slave byte of 0x81.
      for (int m = 0; m < 2; m++) begin
         p = (m == 1);
         waitIdle();
         cpol = p;
         @(negedge clk);
         check("m12 sclk before", sclkW[0], p);
         launch(p, ~p, (m == 0) ? 8'hFF : 8'h00, 8'h81, 1, t0);
         waitDone0(t0, 1'b0, dt);
         check("m12 dout", doutW[0], 8'h81);
         check("m12 sclk after", sclkW[0], p);
         check("m12 mosi bits", slaveRx[0], (m == 0) ? 8'hFF : 8'h00);
      end

      // Back-to-back with start held high.
      waitIdle();
      cpol = 1'b0; cpha = 1'b0; din = 8'h12; slaveByte = 8'h9C;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      din = 8'h34;
      slaveByte = 8'h6B;
      waitDone0(t0, 1'b0, dt);
      check("b2b first cs gap", csW[0], 1'b1);
      check("b2b first dout", doutW[0], 8'h9C);
      check("b2b first mosi", slaveRx[0], 8'h12);
      @(negedge clk);
      t0 = cyc;
      check("b2b restart cs", csW[0], 1'b0);
      waitDone0(t0, 1'b0, dt);
      start = 1'b0;
      check("b2b second dout", doutW[0], 8'h6B);
      check("b2b second mosi", slaveRx[0], 8'h34);

      // Reset just after SCLK edge 7.
      launch(1'b0, 1'b0, 8'h3E, 8'hA7, 1, t0);
      repeat (7 * DivA) @(negedge clk);
      check("abort mid cs", csW[0], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort cs", csW[0], 1'b1);
      check("abort ready", readyW[0], 1'b1);
      check("abort dout", doutW[0], 8'h00);
      launch(1'b1, 1'b0, 8'hC9, 8'h5D, 1, t0);
      waitDone0(t0, 1'b0, dt);
      check("post abort dout", doutW[0], 8'h5D);
      check("post abort mosi", slaveRx[0], 8'hC9);

      // Divider of 2 on the second instance.
      launch(1'b0, 1'b0, 8'h01, 8'h80, 1, t0);
      r1 = -1; r2 = -1; dB = -1;
      p = sclkW[1];
      for (int k = 0; k < 40; k++) begin
         if (sclkW[1] === 1'b1 && p === 1'b0) begin
            if (r1 < 0) r1 = cyc;
            else if (r2 < 0) r2 = cyc;
         end
         if (readyW[1] === 1'b1 && dB < 0) dB = cyc - t0;
         p = sclkW[1];
         @(negedge clk);
      end
      check("div2 sclk period", r2 - r1, 4);
      check("div2 busy cycles", dB, 34);
      check("div2 dout", doutW[1], 8'h80);
      check("div2 mosi bits", slaveRx[1], 8'h01);
      waitDone0(t0, 1'b0, dt);

      // Randomised transfers with input noise while busy.
      for (int r = 0; r < 24; r++) begin
         logic [7:0] rd, rs;
         rd = 8'($urandom);
         rs = 8'($urandom);
         launch(1'($urandom), 1'($urandom), rd, rs, int'($urandom_range(3, 1)), t0);
         waitDone0(t0, 1'b1, dt);
         check("rand dout", doutW[0], rs);
         check("rand mosi", slaveRx[0], rd);
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end

      waitIdle();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", nTests);
      $fatal(1);
   end

endmodule
